score_board: RTL and testbench



---
 rtl/score_board_if.sv | 24 ++
 rtl/score_board.sv | 158 +++++++++++++++
 tb/tb_score_board.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/score_board_if.sv
// Score display bundle between the game controller (master) and score_board (slave).
// Handshake: there is no valid/ready pair. score and fail are levels sampled on
// every clk_100ms tick, and all outputs are registered levels, except busy, which
// is combinational.
interface score_board_if;
    logic [15:0] score;
    logic        fail;
    logic [15:0] cur_bcd;
    logic [15:0] hi_bcd;
    logic        new_record;
    logic        record_blink;
    logic        busy;
    logic [1:0]  dbg_state;

    modport master (
        output score, fail,
        input  cur_bcd, hi_bcd, new_record, record_blink, busy, dbg_state
    );

    modport slave (
        input  score, fail,
        output cur_bcd, hi_bcd, new_record, record_blink, busy, dbg_state
    );
endinterface

// File: rtl/score_board.sv
// Score display tracker. The block mirrors the controller's binary score into a
// saturating 4-digit BCD value, advancing one count per tick. It keeps the session
// high score and drives a blinking new-record flag after game over.
module score_board #(
    parameter int          BLINK_TICKS = 5,
    parameter logic [15:0] BCD_MAX     = 16'h9999
) (
    input logic          clk_100ms,
    input logic          rst,
    score_board_if.slave sb
);
    localparam int             CW       = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(BLINK_TICKS - 1);

    typedef enum logic [1:0] {
        ST_PLAY   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_COMMIT = 2'd2,
        ST_OVER   = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [15:0]   hi_bin_q, hi_bin_d;
    logic [15:0]   cur_bcd_q, cur_bcd_d;
    logic [15:0]   hi_bcd_q, hi_bcd_d;
    logic          new_record_q, new_record_d;
    logic          blink_q, blink_d;
    logic [CW-1:0] blink_cnt_q, blink_cnt_d;
    logic          restart;
    logic          busy;

    // Ripple-carry increment of a 4-digit BCD value. Each digit 9 wraps to 0 and
    // carries into the next digit.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c           = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // A score below the shadow can only mean that the controller started a new game.
    assign restart = sb.score < shadow_q;
    assign busy    = shadow_q != sb.score;

    // Next-state logic: restart first, then catch-up, then game-phase sequencing.
    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        hi_bin_d     = hi_bin_q;
        cur_bcd_d    = cur_bcd_q;
        hi_bcd_d     = hi_bcd_q;
        new_record_d = new_record_q;
        blink_d      = blink_q;
        blink_cnt_d  = blink_cnt_q;

        if (restart) begin
            shadow_d     = 16'd0;
            cur_bcd_d    = 16'd0;
            new_record_d = 1'b0;
            blink_d      = 1'b0;
            blink_cnt_d  = '0;
            state_d      = ST_PLAY;
        end else begin
            if (sb.score > shadow_q) begin
                shadow_d = shadow_q + 16'd1;
                // Once the display saturates, it holds at BCD_MAX while the shadow keeps counting.
                if (cur_bcd_q != BCD_MAX) begin
                    cur_bcd_d = bcd_inc(cur_bcd_q);
                end
            end

            case (state_q)
                ST_PLAY: begin
                    if (sb.fail) begin
                        state_d = busy ? ST_SETTLE : ST_COMMIT;
                    end
                end
                ST_SETTLE: begin
                    if (!sb.fail) begin
                        state_d = ST_PLAY;
                    end else if (!busy) begin
                        state_d = ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    if (shadow_q > hi_bin_q) begin
                        hi_bin_d     = shadow_q;
                        hi_bcd_d     = cur_bcd_q;
                        new_record_d = 1'b1;
                        blink_cnt_d  = '0;
                        blink_d      = 1'b1;
                    end else begin
                        new_record_d = 1'b0;
                        blink_d      = 1'b0;
                    end
                    state_d = ST_OVER;
                end
                default: begin
                    if (!sb.fail) begin
                        blink_d = 1'b0;
                        state_d = ST_PLAY;
                    end else if (new_record_q) begin
                        if (blink_cnt_q == CNT_LAST) begin
                            blink_cnt_d = '0;
                            blink_d     = !blink_q;
                        end else begin
                            blink_cnt_d = blink_cnt_q + CW'(1);
                        end
                    end else begin
                        blink_d = 1'b0;
                    end
                end
            endcase
        end
    end

    // State registers; an asynchronous reset clears everything, including the high score.
    always_ff @(posedge clk_100ms or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_PLAY;
            shadow_q     <= 16'd0;
            hi_bin_q     <= 16'd0;
            cur_bcd_q    <= 16'd0;
            hi_bcd_q     <= 16'd0;
            new_record_q <= 1'b0;
            blink_q      <= 1'b0;
            blink_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            hi_bin_q     <= hi_bin_d;
            cur_bcd_q    <= cur_bcd_d;
            hi_bcd_q     <= hi_bcd_d;
            new_record_q <= new_record_d;
            blink_q      <= blink_d;
            blink_cnt_q  <= blink_cnt_d;
        end
    end

    assign sb.cur_bcd      = cur_bcd_q;
    assign sb.hi_bcd       = hi_bcd_q;
    assign sb.new_record   = new_record_q;
    assign sb.record_blink = blink_q;
    assign sb.busy         = busy;
    assign sb.dbg_state    = state_q;
endmodule

// File: tb/tb_score_board.sv
// Randomized and directed bench for score_board, checked against a behavioural game-score model.
module tb_score_board;
    localparam int BLINK = 5;

    logic clk_100ms = 1'b0;
    logic rst       = 1'b0;
    score_board_if sb_if ();

    score_board #(.BLINK_TICKS(BLINK), .BCD_MAX(16'h9999)) dut (
        .clk_100ms (clk_100ms),
        .rst       (rst),
        .sb        (sb_if)
    );

    always #5 clk_100ms = ~clk_100ms;

    int n_vec = 0;
    int n_err = 0;

    // Model of the game: the displayed count, the best score, the game phase and the record-blink timing.
    int m_shown;
    int m_best;
    int m_phase;     // 0 playing, 1 waiting for the display, 2 committing, 3 game over
    int m_rec;
    int m_blink;
    int m_blink_age;

    function automatic logic [15:0] to_bcd(input int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return 16'(((s / 1000) % 10) * 4096 + ((s / 100) % 10) * 256 + ((s / 10) % 10) * 16 + (s % 10));
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_shown = 0; m_best = 0; m_phase = 0; m_rec = 0; m_blink = 0; m_blink_age = 0;
    endtask

    // Advances the model by one tick using the inputs presented before the edge.
    task automatic model_step();
        int sc;
        int old;
        sc  = int'(sb_if.score);
        old = m_shown;
        if (sc < old) begin
            m_shown = 0; m_rec = 0; m_blink = 0; m_blink_age = 0; m_phase = 0;
        end else begin
            if (sc > old) m_shown = old + 1;
            case (m_phase)
                0: if (sb_if.fail) m_phase = (sc != old) ? 1 : 2;
                1: if (!sb_if.fail) m_phase = 0; else if (sc == old) m_phase = 2;
                2: begin
                    if (old > m_best) begin
                        m_best = old; m_rec = 1; m_blink = 1; m_blink_age = 0;
                    end else begin
                        m_rec = 0; m_blink = 0;
                    end
                    m_phase = 3;
                end
                default: begin
                    if (!sb_if.fail) begin
                        m_blink = 0; m_phase = 0;
                    end else if (m_rec == 1) begin
                        m_blink_age++;
                        if (m_blink_age == BLINK) begin
                            m_blink_age = 0;
                            m_blink     = 1 - m_blink;
                        end
                    end else begin
                        m_blink = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic check_all();
        check("cur_bcd", 32'(sb_if.cur_bcd), 32'(to_bcd(m_shown)));
        check("hi_bcd", 32'(sb_if.hi_bcd), 32'(to_bcd(m_best)));
        check("new_record", 32'(sb_if.new_record), 32'(m_rec));
        check("record_blink", 32'(sb_if.record_blink), 32'(m_blink));
        check("busy", 32'(sb_if.busy), 32'(m_shown != int'(sb_if.score)));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_100ms);
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic async_reset_pulse();
        rst = 1'b0;
        #1;
        model_clear();
        check_all();
        @(posedge clk_100ms);
        #1;
        check_all();
        rst = 1'b1;
    endtask

    initial begin
        int r;
        int sc;
        sb_if.score = 16'd0;
        sb_if.fail  = 1'b0;
        model_clear();

        // Reset state, then an idle hold.
        #2;
        check_all();
        check("dbg_state_reset", 32'(sb_if.dbg_state), 32'd0);
        @(posedge clk_100ms);
        #1;
        rst = 1'b1;
        ticks(10);

        // Single steps and a +2 step.
        sb_if.score = 16'd1; tick();
        sb_if.score = 16'd3; tick();
        sb_if.score = 16'd4; tick();
        ticks(3);

        // Digit carries and saturation at 9999.
        sb_if.score = 16'd10; ticks(8);
        sb_if.score = 16'd10005; ticks(10005);
        check("saturated", 32'(sb_if.cur_bcd), 32'h9999);

        // First game over sets a record and the display blinks.
        sb_if.score = 16'd12; ticks(14);
        sb_if.fail = 1'b1; ticks(22);
        check("first_record_hi", 32'(sb_if.hi_bcd), 32'h0012);

        // An equal score is not a record; a higher one is.
        sb_if.score = 16'd0; sb_if.fail = 1'b0; tick();
        sb_if.score = 16'd12; ticks(14);
        sb_if.fail = 1'b1; ticks(6);
        check("equal_no_record", 32'(sb_if.new_record), 32'd0);
        sb_if.score = 16'd0; sb_if.fail = 1'b0; tick();
        sb_if.score = 16'd13; ticks(15);
        sb_if.fail = 1'b1; ticks(4);
        check("higher_record_hi", 32'(sb_if.hi_bcd), 32'h0013);

        // Score jump with fail in the same tick, then an asynchronous reset during game over.
        async_reset_pulse();
        sb_if.score = 16'd3; sb_if.fail = 1'b1; ticks(8);
        check("settle_hi", 32'(sb_if.hi_bcd), 32'h0003);
        async_reset_pulse();
        check("rst_hi", 32'(sb_if.hi_bcd), 32'h0000);

        // Random play: steps, fail toggles, restarts and occasional resets.
        sb_if.score = 16'd0; sb_if.fail = 1'b0; tick();
        for (int k = 0; k < 3000; k++) begin
            r  = int'($urandom_range(0, 199));
            sc = int'(sb_if.score);
            if (r < 4) begin
                sb_if.score = 16'($urandom_range(0, sc));
                sb_if.fail  = 1'b0;
            end else if (r < 14) begin
                sb_if.fail = ~sb_if.fail;
            end else if (r == 199) begin
                async_reset_pulse();
            end else if (sc < 60000) begin
                sb_if.score = 16'(sc + int'($urandom_range(0, 2)));
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
